// File: rtl/branch_predict_resolve.sv
// Branch unit: IF-stage prediction (2-bit BHT + direct-mapped BTB) and EX-stage
// resolution with mispredict flush/redirect, table training and perf counters.
module branch_predict_resolve #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [XLEN-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [3:0]       ex_op,
  input  logic [XLEN-1:0]  ex_data1,
  input  logic [XLEN-1:0]  ex_data2,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             ex_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int ENTRIES = 2 ** IDX_W;

  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BGE  = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;

  logic [1:0]       bht        [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [XLEN-1:0]  btb_target [ENTRIES];
  logic [ENTRIES-1:0] btb_valid;
  logic [ENTRIES-1:0] btb_jmp;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic [XLEN-1:0]  if_pc_plus4, ex_pc_plus4;
  logic             cond, is_cond, is_jump, ex_active;

  // Address bits outside the index/tag window are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[XLEN-1:IDX_W+TAG_W+2],
                            ex_pc[1:0], ex_pc[XLEN-1:IDX_W+TAG_W+2]};

  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag      = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx      = ex_pc[IDX_W+1:2];
  assign ex_tag      = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_pc_plus4 = if_pc + XLEN'(4);
  assign ex_pc_plus4 = ex_pc + XLEN'(4);

  assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

  assign if_pred_taken  = reset_n && if_hit && (btb_jmp[if_idx] || bht[if_idx][1]);
  assign if_pred_target = (reset_n && if_hit) ? btb_target[if_idx] : if_pc_plus4;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cond    = 1'b0;
    is_cond = 1'b0;
    is_jump = 1'b0;
    case (ex_op)
      OP_BEQ:  begin is_cond = 1'b1; cond = (ex_data1 == ex_data2); end
      OP_BNE:  begin is_cond = 1'b1; cond = (ex_data1 != ex_data2); end
      OP_BLT:  begin is_cond = 1'b1; cond = ($signed(ex_data1) <  $signed(ex_data2)); end
      OP_BGE:  begin is_cond = 1'b1; cond = ($signed(ex_data1) >= $signed(ex_data2)); end
      OP_BLTU: begin is_cond = 1'b1; cond = (ex_data1 <  ex_data2); end
      OP_BGEU: begin is_cond = 1'b1; cond = (ex_data1 >= ex_data2); end
      OP_JMP:  begin is_jump = 1'b1; cond = 1'b1; end
      default: ;
    endcase
  end

  assign ex_active   = reset_n && ex_valid;
  assign ex_taken    = ex_active && cond;
  assign flush       = ex_active && ((ex_taken != ex_pred_taken) ||
                                     (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = !reset_n ? '0 : (ex_taken ? ex_target : ex_pc_plus4);

  // NOTE: state registers use non-blocking assignments; direction bits and
  // counters need a defined reset value, so they live in the reset process.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
      btb_valid     <= '0;
      btb_jmp       <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else if (ex_valid) begin
      if (is_cond) begin
        if (cond) begin
          if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
          btb_valid[ex_idx] <= 1'b1;
          btb_jmp[ex_idx]   <= 1'b0;
        end else if (bht[ex_idx] != 2'b00) begin
          bht[ex_idx] <= bht[ex_idx] - 2'b01;
        end
      end else if (is_jump) begin
        bht[ex_idx]       <= 2'b11;
        btb_valid[ex_idx] <= 1'b1;
        btb_jmp[ex_idx]   <= 1'b1;
      end else if (!ex_op[3] && ex_hit) begin
        btb_valid[ex_idx] <= 1'b0;
      end
      if (ex_op[3] && (br_count != '1))   br_count      <= br_count + 1'b1;
      if (flush && (mispred_count != '1)) mispred_count <= mispred_count + 1'b1;
    end
  end

  // NOTE: tag/target storage is not reset; the valid bit alone guards it.
  always_ff @(posedge clk) begin
    if (reset_n && ex_valid && ((is_cond && cond) || is_jump)) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= ex_target;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: a resolution vector table plus
// hand-written sequences for training, aliasing, same-cycle update and reset.
module tb_branch_predict_resolve;

  localparam logic [3:0] BEQ = 4'b1000, BNE = 4'b1001, JAL = 4'b1010, RSV = 4'b1011;
  localparam logic [3:0] BLT = 4'b1100, BGE = 4'b1101, BLTU = 4'b1110, BGEU = 4'b1111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_op;
  logic [31:0] ex_data1, ex_data2, ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_taken, flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_count, mispred_count;

  int total = 0;
  int bad   = 0;

  branch_predict_resolve dut (
    .clk(clk), .reset_n(reset_n),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .flush(flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        pt;
    logic [31:0] ptgt;
    logic        exp_taken;
    logic        exp_flush;
    logic [31:0] exp_redirect;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] op,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_op = op; ex_data1 = d1; ex_data2 = d2;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({name, "_taken"}, if_pred_taken, exp_t);
    check({name, "_target"}, if_pred_target, exp_tgt);
  endtask

  task automatic counts(input string name, input int exp_br, input int exp_mis);
    check({name, "_br"}, br_count, exp_br);
    check({name, "_mis"}, mispred_count, exp_mis);
  endtask

  initial begin
    // Resolution table at pc=0x1000, target=0x2000 (not-taken path is 0x1004).
    vecs[0]  = '{BEQ,  32'd3,          32'd4,          1'b0, 32'h0,    1'b0, 1'b0, 32'h1004};
    vecs[1]  = '{BNE,  32'd3,          32'd4,          1'b0, 32'h0,    1'b1, 1'b1, 32'h2000};
    vecs[2]  = '{BNE,  32'd7,          32'd7,          1'b1, 32'h2000, 1'b0, 1'b1, 32'h1004};
    vecs[3]  = '{BLT,  32'hFFFFFFFF,   32'd0,          1'b1, 32'h2000, 1'b1, 1'b0, 32'h2000};
    vecs[4]  = '{BLTU, 32'hFFFFFFFF,   32'd0,          1'b0, 32'h0,    1'b0, 1'b0, 32'h1004};
    vecs[5]  = '{BGE,  32'd0,          32'hFFFFFFFF,   1'b1, 32'h1234, 1'b1, 1'b1, 32'h2000};
    vecs[6]  = '{BGEU, 32'd0,          32'hFFFFFFFF,   1'b0, 32'h0,    1'b0, 1'b0, 32'h1004};
    vecs[7]  = '{BGE,  32'd5,          32'd5,          1'b1, 32'h2000, 1'b1, 1'b0, 32'h2000};
    vecs[8]  = '{BLTU, 32'd1,          32'd2,          1'b0, 32'h0,    1'b1, 1'b1, 32'h2000};
    vecs[9]  = '{JAL,  32'd0,          32'd0,          1'b1, 32'h2000, 1'b1, 1'b0, 32'h2000};
    vecs[10] = '{RSV,  32'd1,          32'd1,          1'b0, 32'h0,    1'b0, 1'b0, 32'h1004};
    vecs[11] = '{4'b0000, 32'd1,       32'd1,          1'b0, 32'h0,    1'b0, 1'b0, 32'h1004};
    vecs[12] = '{4'b0110, 32'd1,       32'd1,          1'b1, 32'h2000, 1'b0, 1'b1, 32'h1004};

    // Reset state: outputs gated even with a live EX instruction.
    reset_n = 1'b0;
    if_pc   = 32'h100;
    drive(1'b1, 32'h100, BEQ, 32'd5, 32'd5, 32'h400, 1'b0, 32'h0);
    #1;
    check("rst_if_taken", if_pred_taken, 1'b0);
    check("rst_if_target", if_pred_target, 32'h104);
    check("rst_ex_taken", ex_taken, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_redirect", redirect_pc, 32'h0);
    cycle();
    cycle();
    reset_n = 1'b1;
    ex_valid = 1'b0;
    lookup("post_rst", 32'h100, 1'b0, 32'h104);
    lookup("wrap", 32'hFFFFFFFC, 1'b0, 32'h0);
    counts("post_rst", 0, 0);

    // Table-driven resolution.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 32'h1000, vecs[i].op, vecs[i].d1, vecs[i].d2, 32'h2000,
            vecs[i].pt, vecs[i].ptgt);
      #1;
      check($sformatf("vec%0d_taken", i), ex_taken, vecs[i].exp_taken);
      check($sformatf("vec%0d_flush", i), flush, vecs[i].exp_flush);
      if (vecs[i].exp_flush) check($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].exp_redirect);
      cycle();
    end
    ex_valid = 1'b0;
    #1;
    counts("table", 11, 5);

    // Clear tables before the training sequences.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    cycle();
    counts("rst2", 0, 0);

    // BEQ taken, predicted NT.
    if_pc = 32'h40;
    drive(1'b1, 32'h100, BEQ, 32'd5, 32'd5, 32'h400, 1'b0, 32'h0);
    #1;
    check("beq_taken", ex_taken, 1'b1);
    check("beq_flush", flush, 1'b1);
    check("beq_redirect", redirect_pc, 32'h400);
    cycle();
    ex_valid = 1'b0;
    lookup("beq_lk", 32'h100, 1'b1, 32'h400);
    counts("beq", 1, 1);

    // BLT signed: taken x3, then NT (11->10, still taken), then NT again (->01).
    drive(1'b1, 32'h104, BLT, 32'h80000000, 32'd1, 32'h500, 1'b0, 32'h0);
    #1;
    check("blt1_flush", flush, 1'b1);
    cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h104, BLT, 32'h80000000, 32'd1, 32'h500, 1'b1, 32'h500);
      #1;
      check("bltk_taken", ex_taken, 1'b1);
      check("bltk_flush", flush, 1'b0);
      cycle();
    end
    ex_valid = 1'b0;
    lookup("blt_sat", 32'h104, 1'b1, 32'h500);
    drive(1'b1, 32'h104, BLT, 32'd1, 32'h80000000, 32'h500, 1'b1, 32'h500);
    #1;
    check("blt_nt_taken", ex_taken, 1'b0);
    check("blt_nt_flush", flush, 1'b1);
    check("blt_nt_redirect", redirect_pc, 32'h108);
    cycle();
    ex_valid = 1'b0;
    lookup("blt_10", 32'h104, 1'b1, 32'h500);
    drive(1'b1, 32'h104, BLT, 32'd1, 32'h80000000, 32'h500, 1'b1, 32'h500);
    cycle();
    ex_valid = 1'b0;
    lookup("blt_01", 32'h104, 1'b0, 32'h500);
    counts("blt", 6, 4);

    // BGEU correctly predicted: no flush.
    drive(1'b1, 32'h108, BGEU, 32'hFFFFFFFF, 32'd1, 32'h600, 1'b1, 32'h600);
    #1;
    check("bgeu_taken", ex_taken, 1'b1);
    check("bgeu_flush", flush, 1'b0);
    cycle();
    ex_valid = 1'b0;
    #1;
    counts("bgeu", 7, 4);

    // JAL, then a non-branch at an aliasing PC evicts the entry.
    drive(1'b1, 32'h200, JAL, 32'd0, 32'd0, 32'h800, 1'b0, 32'h0);
    #1;
    check("jal_flush", flush, 1'b1);
    cycle();
    ex_valid = 1'b0;
    lookup("jal_lk", 32'h200, 1'b1, 32'h800);
    drive(1'b1, 32'h10200, 4'b0000, 32'd0, 32'd0, 32'h0, 1'b1, 32'h800);
    #1;
    check("alias_taken", ex_taken, 1'b0);
    check("alias_flush", flush, 1'b1);
    check("alias_redirect", redirect_pc, 32'h10204);
    cycle();
    ex_valid = 1'b0;
    lookup("alias_lk", 32'h200, 1'b0, 32'h204);
    counts("alias", 8, 6);

    // Same-cycle lookup and update: lookup sees old contents.
    drive(1'b1, 32'h30C, BEQ, 32'd9, 32'd9, 32'h900, 1'b0, 32'h0);
    lookup("same_pre", 32'h30C, 1'b0, 32'h310);
    cycle();
    drive(1'b0, 32'h30C, JAL, 32'hDEAD, 32'hBEEF, 32'hDEAD0000, 1'b1, 32'h0);
    #1;
    check("bubble_taken", ex_taken, 1'b0);
    check("bubble_flush", flush, 1'b0);
    lookup("same_post", 32'h30C, 1'b1, 32'h900);
    cycle();
    lookup("bubble_hold", 32'h30C, 1'b1, 32'h900);
    counts("bubble", 9, 7);

    // Reset asserted in the middle of a training cycle.
    drive(1'b1, 32'h30C, JAL, 32'd0, 32'd0, 32'hA00, 1'b0, 32'h0);
    #3;
    reset_n = 1'b0;
    #1;
    counts("midrst", 0, 0);
    check("midrst_flush", flush, 1'b0);
    check("midrst_redirect", redirect_pc, 32'h0);
    lookup("midrst_lk", 32'h30C, 1'b0, 32'h310);
    cycle();
    reset_n = 1'b1;
    ex_valid = 1'b0;
    lookup("after_rst_a", 32'h30C, 1'b0, 32'h310);
    lookup("after_rst_b", 32'h104, 1'b0, 32'h108);
    counts("after_rst", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
